// File: rtl/dma_modport.sv
// Single-channel memory-to-memory DMA engine with a private word memory,
// programmed and observed entirely through one simple read/write register bus.
module dma_modport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int RA_W  = ADDR_WIDTH - 1;

  localparam logic [RA_W-1:0] REG_CTRL   = RA_W'(0);
  localparam logic [RA_W-1:0] REG_SRC    = RA_W'(1);
  localparam logic [RA_W-1:0] REG_DST    = RA_W'(2);
  localparam logic [RA_W-1:0] REG_LEN    = RA_W'(3);
  localparam logic [RA_W-1:0] REG_STATUS = RA_W'(4);
  localparam logic [RA_W-1:0] REG_COUNT  = RA_W'(5);
  localparam logic [7:0]      LEN_MAX    = 8'(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t                state_reg;
  logic [IDX_W-1:0]      src_reg;
  logic [IDX_W-1:0]      dst_reg;
  logic [7:0]            len_reg;
  logic [7:0]            count_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  error_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [DATA_WIDTH-1:0] reg_rd;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic             sel_mem;
  logic [RA_W-1:0]  reg_addr;
  logic             wr_reg;
  logic             ctrl_wr;
  logic             start_req;
  logic             abort_req;
  logic             len_bad;
  logic             last_word;
  logic             eng_we;
  logic             bus_mem_we;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;

  assign sel_mem    = addr[ADDR_WIDTH-1];
  assign reg_addr   = addr[RA_W-1:0];
  assign wr_reg     = wr_en && !sel_mem;
  assign ctrl_wr    = wr_reg && (reg_addr == REG_CTRL);
  // A CTRL write carrying ABORT never starts a transfer, busy or not.
  assign start_req  = ctrl_wr && wdata[0] && !wdata[1];
  assign abort_req  = ctrl_wr && wdata[1];
  assign len_bad    = (len_reg == 8'd0) || (len_reg > LEN_MAX);
  assign last_word  = ((count_reg + 8'd1) == len_reg);
  assign rd_idx     = src_reg + count_reg[IDX_W-1:0];
  assign wr_idx     = dst_reg + count_reg[IDX_W-1:0];
  assign eng_we     = (state_reg == WR) && !(busy_reg && abort_req);
  assign bus_mem_we = wr_en && sel_mem && !busy_reg;
  assign rdata      = rdata_reg;

  always_comb begin
    reg_rd = '0;
    case (reg_addr)
      REG_SRC:    reg_rd = DATA_WIDTH'(src_reg);
      REG_DST:    reg_rd = DATA_WIDTH'(dst_reg);
      REG_LEN:    reg_rd = DATA_WIDTH'(len_reg);
      REG_STATUS: reg_rd = {{(DATA_WIDTH-3){1'b0}}, error_reg, done_reg, busy_reg};
      REG_COUNT:  reg_rd = DATA_WIDTH'(count_reg);
      default:    reg_rd = '0;
    endcase
  end

  // Engine and bus never write the memory in the same cycle: bus writes are gated by busy.
  always_ff @(posedge clk) begin
    if (eng_we) begin
      mem[wr_idx] <= data_reg;
    end else if (bus_mem_we) begin
      mem[addr[IDX_W-1:0]] <= wdata;
    end
    if (state_reg == RD) begin
      data_reg <= mem[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      src_reg   <= '0;
      dst_reg   <= '0;
      len_reg   <= '0;
      count_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
      rdata_reg <= '0;
    end else begin
      if (rd_en && !wr_en) begin
        if (sel_mem) begin
          rdata_reg <= busy_reg ? '0 : mem[addr[IDX_W-1:0]];
        end else begin
          rdata_reg <= reg_rd;
        end
      end

      if (wr_reg && !busy_reg) begin
        if (reg_addr == REG_SRC) src_reg <= wdata[IDX_W-1:0];
        if (reg_addr == REG_DST) dst_reg <= wdata[IDX_W-1:0];
        if (reg_addr == REG_LEN) len_reg <= wdata[7:0];
      end

      if (wr_reg && (reg_addr == REG_STATUS)) begin
        if (wdata[1]) done_reg  <= 1'b0;
        if (wdata[2]) error_reg <= 1'b0;
      end

      if (busy_reg && abort_req) begin
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
        error_reg <= 1'b1;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start_req) begin
              if (len_bad) begin
                error_reg <= 1'b1;
              end else begin
                busy_reg  <= 1'b1;
                done_reg  <= 1'b0;
                count_reg <= '0;
                state_reg <= RD;
              end
            end
          end
          RD: state_reg <= WR;
          WR: begin
            count_reg <= count_reg + 8'd1;
            if (last_word) begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= IDLE;
            end else begin
              state_reg <= RD;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dma_modport.sv
// Bench for dma_modport: register/memory vector table, hand-written copy, wrap,
// error, abort and reset sequences, plus randomized transfers against an array model.
module tb_dma_modport;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] wdata = '0;
  logic [7:0]  addr  = '0;
  logic [31:0] rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] model_mem [128];
  int          model_count = 0;

  typedef struct {
    bit          is_wr;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [14];

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  dma_modport #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .MEM_DEPTH(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .wdata (wdata),
    .addr  (addr),
    .rdata (rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Each bus op drives right after an edge and completes 1 time unit after the next edge.
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    wr_en = 1'b1; rd_en = 1'b0; addr = a; wdata = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    rd_en = 1'b1; wr_en = 1'b0; addr = a;
    @(posedge clk); #1;
    rd_en = 1'b0;
    d = rdata;
  endtask

  task automatic mem_wr(input int idx, input logic [31:0] d);
    wr(8'h80 | 8'(idx), d);
    model_mem[idx] = d;
  endtask

  task automatic check_mem(input string tag);
    logic [31:0] v;
    for (int i = 0; i < 128; i++) begin
      rd(8'h80 | 8'(i), v);
      check($sformatf("%s_mem[%0d]", tag, i), v, model_mem[i]);
    end
  endtask

  // Program, start, poll STATUS until idle, then check status, timing, count, memory and W1C.
  task automatic run_copy(input int src, input int dst, input int len, input string tag);
    logic [31:0] s;
    logic [31:0] v;
    int busy_n;
    int polls;
    int exp_status;
    int exp_busy;
    wr(8'h01, 32'(src));
    wr(8'h02, 32'(dst));
    wr(8'h03, 32'(len));
    wr(8'h00, 32'h1);
    busy_n = 0;
    polls  = 0;
    s      = 32'h1;
    while (s[0] && polls < 600) begin
      rd(8'h04, s);
      polls++;
      if (s[0]) busy_n++;
    end
    if (s[0]) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got busy after %0d polls want idle", tag, polls);
    end
    if (len == 0 || len > 128) begin
      exp_status = 4;
      exp_busy   = 0;
    end else begin
      exp_status = 2;
      exp_busy   = 2 * len;
      for (int i = 0; i < len; i++)
        model_mem[(dst + i) % 128] = model_mem[(src + i) % 128];
      model_count = len;
    end
    check({tag, "_status"}, s, 32'(exp_status));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
    rd(8'h05, v);
    check({tag, "_count"}, v, 32'(model_count));
    $display("xfer %s src=%0d dst=%0d len=%0d status=%h count=%0d", tag, src, dst, len, s, v);
    check_mem(tag);
    wr(8'h04, 32'(6 ^ exp_status));
    rd(8'h04, v);
    check({tag, "_w1c_other"}, v, 32'(exp_status));
    wr(8'h04, 32'(exp_status));
    rd(8'h04, v);
    check({tag, "_w1c_clear"}, v, 32'h0);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;

    vt[0]  = '{1'b1, 8'h85, 32'hDEADBEEF, 32'h0};
    vt[1]  = '{1'b0, 8'h85, 32'h0,        32'hDEADBEEF};
    vt[2]  = '{1'b1, 8'h01, 32'hFFFFFFFF, 32'h0};
    vt[3]  = '{1'b0, 8'h01, 32'h0,        32'h0000007F};
    vt[4]  = '{1'b1, 8'h02, 32'h00000123, 32'h0};
    vt[5]  = '{1'b0, 8'h02, 32'h0,        32'h00000023};
    vt[6]  = '{1'b1, 8'h03, 32'hABCD01F0, 32'h0};
    vt[7]  = '{1'b0, 8'h03, 32'h0,        32'h000000F0};
    vt[8]  = '{1'b0, 8'h00, 32'h0,        32'h0};
    vt[9]  = '{1'b1, 8'h06, 32'hFFFFFFFF, 32'h0};
    vt[10] = '{1'b0, 8'h06, 32'h0,        32'h0};
    vt[11] = '{1'b0, 8'h7F, 32'h0,        32'h0};
    vt[12] = '{1'b1, 8'hFF, 32'h00005A5A, 32'h0};
    vt[13] = '{1'b0, 8'hFF, 32'h0,        32'h00005A5A};

    // Reset: rdata stays 0 even with a read strobe held.
    rd_en = 1'b1; addr = 8'h85;
    repeat (3) @(posedge clk);
    #1;
    check("rdata_in_reset", rdata, 32'h0);
    rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd(8'h04, v); check("reset_status", v, 32'h0);
    rd(8'h05, v); check("reset_count", v, 32'h0);
    rd(8'h01, v); check("reset_src", v, 32'h0);

    for (int i = 0; i < 128; i++) mem_wr(i, $urandom | 32'h1);

    for (int i = 0; i < 14; i++) begin
      if (vt[i].is_wr) begin
        wr(vt[i].a, vt[i].d);
        if (vt[i].a[7]) model_mem[vt[i].a[6:0]] = vt[i].d;
        $display("vec %0d wr addr=%h data=%h", i, vt[i].a, vt[i].d);
      end else begin
        rd(vt[i].a, v);
        check($sformatf("vec%0d_rd_%h", i, vt[i].a), v, vt[i].exp);
        $display("vec %0d rd addr=%h data=%h", i, vt[i].a, v);
      end
    end

    // rdata holds with rd_en low, and a simultaneous write drops the read.
    @(posedge clk); #1;
    check("rdata_hold", rdata, 32'h00005A5A);
    wr_en = 1'b1; rd_en = 1'b1; addr = 8'h84; wdata = 32'h00000077;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    model_mem[4] = 32'h00000077;
    check("wr_rd_drop", rdata, 32'h00005A5A);
    rd(8'h84, v); check("wr_rd_write_done", v, 32'h00000077);

    // Basic copy.
    for (int i = 0; i < 4; i++) mem_wr(i, 32'(i + 1));
    run_copy(0, 16, 4, "basic");
    for (int i = 0; i < 4; i++) begin
      rd(8'h90 + 8'(i), v);
      check($sformatf("basic_dst%0d", i), v, 32'(i + 1));
    end

    // Wrap around the top of memory.
    w0 = model_mem[126]; w1 = model_mem[127]; w2 = model_mem[0];
    run_copy(126, 64, 3, "wrap");
    rd(8'hC0, v); check("wrap_d0", v, w0);
    rd(8'hC1, v); check("wrap_d1", v, w1);
    rd(8'hC2, v); check("wrap_d2", v, w2);

    run_copy(16, 32, 0, "len0");
    run_copy(16, 32, 129, "len129");
    run_copy(0, 127, 128, "len128");

    // Abort after three words, with blocked writes and a blocked memory read mid-transfer.
    wr(8'h01, 32'h20); wr(8'h02, 32'h60); wr(8'h03, 32'd10);
    wr(8'h00, 32'h1);
    wr(8'h01, 32'h55);
    rd(8'h01, v); check("abort_src_locked", v, 32'h20);
    rd(8'hA0, v); check("abort_mem_rd_busy", v, 32'h0);
    wr(8'hE8, 32'h12345678);
    repeat (2) @(posedge clk);
    #1;
    wr(8'h00, 32'h2);
    rd(8'h04, v); check("abort_status", v, 32'h4);
    rd(8'h05, v); check("abort_count", v, 32'd3);
    $display("xfer abort src=32 dst=96 len=10 status=4 count=%0d", v);
    for (int i = 0; i < 3; i++) model_mem[96 + i] = model_mem[32 + i];
    model_count = 3;
    check_mem("abort");
    wr(8'h04, 32'h4);
    wr(8'h00, 32'h2);
    rd(8'h04, v); check("abort_idle_noop", v, 32'h0);

    // Randomized transfers.
    for (int r = 0; r < 12; r++) begin
      int sel;
      int len;
      for (int k = 0; k < 3; k++) mem_wr($urandom_range(0, 127), $urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) len = 0;
      else if (sel == 1) len = $urandom_range(129, 255);
      else len = $urandom_range(1, 24);
      run_copy($urandom_range(0, 127), $urandom_range(0, 127), len, $sformatf("rnd%0d", r));
    end

    // Asynchronous reset mid-transfer.
    wr(8'h01, 32'h0); wr(8'h02, 32'h30); wr(8'h03, 32'd20);
    wr(8'h00, 32'h1);
    rd(8'h03, v); check("rst_len_before", v, 32'd20);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd(8'h04, v); check("rst_status", v, 32'h0);
    rd(8'h05, v); check("rst_count", v, 32'h0);
    rd(8'h03, v); check("rst_len", v, 32'h0);
    rd(8'h02, v); check("rst_dst", v, 32'h0);
    $display("xfer reset_mid src=0 dst=48 len=20 status=%h", v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
